// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline: load-use, EX redirect,
// multi-cycle EX ops and data-memory wait states. HAZ_PERF_CNT_EN adds perf counters.
module pipeline_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              ex_valid,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_memread,
  input  logic              ex_redirect,
  input  logic              ex_multicycle,
  input  logic              mem_busy,
  output logic              pc_stall,
  output logic              pc_redirect,
  output logic              if_id_stall,
  output logic              if_id_flush,
  output logic              id_ex_stall,
  output logic              id_ex_flush,
  output logic              ex_mem_stall,
  output logic              ex_mem_flush,
  output logic              mc_done,
  output logic              mc_busy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int CW = (MC_LAT > 2) ? $clog2(MC_LAT - 1) : 1;
  localparam logic [CW-1:0] CNT_INIT = (MC_LAT > 1) ? CW'(MC_LAT - 2) : '0;

  typedef enum logic {RUN, MC_BUSY} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic load_use;
  logic pc_stall_c, pc_redirect_c, if_id_stall_c, if_id_flush_c;
  logic id_ex_stall_c, id_ex_flush_c, ex_mem_stall_c, ex_mem_flush_c, mc_done_c;

  assign load_use = ex_valid & ex_memread & id_valid & (ex_rd != '0) &
                    ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    pc_stall_c     = 1'b0;
    pc_redirect_c  = 1'b0;
    if_id_stall_c  = 1'b0;
    if_id_flush_c  = 1'b0;
    id_ex_stall_c  = 1'b0;
    id_ex_flush_c  = 1'b0;
    ex_mem_stall_c = 1'b0;
    ex_mem_flush_c = 1'b0;
    mc_done_c      = 1'b0;
    if (mem_busy) begin
      // Whole pipe frozen; a pending redirect stays in EX and fires afterwards.
      pc_stall_c     = 1'b1;
      if_id_stall_c  = 1'b1;
      id_ex_stall_c  = 1'b1;
      ex_mem_stall_c = 1'b1;
    end else if (state_q == MC_BUSY) begin
      if (cnt_q != '0) begin
        pc_stall_c     = 1'b1;
        if_id_stall_c  = 1'b1;
        id_ex_stall_c  = 1'b1;
        ex_mem_flush_c = 1'b1;
        cnt_d          = cnt_q - 1'b1;
      end else begin
        mc_done_c = 1'b1;
        state_d   = RUN;
      end
    end else if (ex_valid && ex_multicycle) begin
      if (MC_LAT == 1) begin
        mc_done_c = 1'b1;
      end else begin
        // Entry cycle is the first of MC_LAT-1 stall cycles.
        pc_stall_c     = 1'b1;
        if_id_stall_c  = 1'b1;
        id_ex_stall_c  = 1'b1;
        ex_mem_flush_c = 1'b1;
        cnt_d          = CNT_INIT;
        state_d        = MC_BUSY;
      end
    end else if (ex_valid && ex_redirect) begin
      pc_redirect_c = 1'b1;
      if_id_flush_c = 1'b1;
      id_ex_flush_c = 1'b1;
    end else if (load_use) begin
      pc_stall_c    = 1'b1;
      if_id_stall_c = 1'b1;
      id_ex_flush_c = 1'b1;
    end
  end

  assign pc_stall     = pc_stall_c     & ~reset;
  assign pc_redirect  = pc_redirect_c  & ~reset;
  assign if_id_stall  = if_id_stall_c  & ~reset;
  assign if_id_flush  = if_id_flush_c  & ~reset;
  assign id_ex_stall  = id_ex_stall_c  & ~reset;
  assign id_ex_flush  = id_ex_flush_c  & ~reset;
  assign ex_mem_stall = ex_mem_stall_c & ~reset;
  assign ex_mem_flush = ex_mem_flush_c & ~reset;
  assign mc_done      = mc_done_c      & ~reset;
  assign mc_busy      = (state_q == MC_BUSY) & ~reset;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (pc_stall && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 1'b1;
    if (pc_redirect && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
